// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
// Shared types and helpers for ram_port_arbiter.
//   MAX_REQ    : largest requester count the helpers support. N_REQ must be
//                strictly smaller than this.
//   IDX_W      : width of a requester index inside a read-tracking entry.
//   rd_entry_t : one read-tracking pipe slot {valid, requester index}.
//   rr_pick    : round-robin winner search. Returns a one-hot vector with
//                the first set bit of req at or after ptr, modulo n_req.
package ram_port_arbiter_pkg;

  localparam int MAX_REQ    = 32;
  localparam int IDX_W      = 5;
  localparam int IDX_SUM_W  = IDX_W + 1;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rd_entry_t;

  // ptr is below n_req and i is below MAX_REQ, so ptr+i fits in IDX_SUM_W
  // bits. One conditional subtract is then enough to wrap at n_req, which
  // need not be a power of 2.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n_req
  );
    logic [MAX_REQ-1:0]   gnt;
    logic                 found;
    logic [IDX_SUM_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + IDX_SUM_W'(i);
      if (idx >= IDX_SUM_W'(n_req)) begin
        idx = idx - IDX_SUM_W'(n_req);
      end
      if ((i < n_req) && !found && req[idx[IDX_W-1:0]]) begin
        gnt[idx[IDX_W-1:0]] = 1'b1;
        found               = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rd_ack_pipe.sv
// rd_ack_pipe
// RD_LAT-deep shift register of read-tracking entries. It lines up each read
// grant with the cycle in which the RAM returns its data.
//   i_clk, i_async_rst : clock and asynchronous active-high reset.
//   i_entry            : entry pushed this cycle. It is {0, x} when there is
//                        no read grant.
//   o_entry            : pipe tail, which is the entry pushed RD_LAT cycles ago.
module rd_ack_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic      i_clk,
  input  logic      i_async_rst,
  input  rd_entry_t i_entry,
  output rd_entry_t o_entry
);

  rd_entry_t [RD_LAT-1:0] pipe_q;
  rd_entry_t [RD_LAT-1:0] pipe_d;

  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = i_entry;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset clears every slot, so no pre-reset read can be acknowledged later.
  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_entry = pipe_q[RD_LAT-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM among N_REQ requesters. Arbitration is
// round-robin with a zero-cycle grant. A write is acknowledged one cycle after
// its grant. A read is acknowledged RD_LAT cycles after its grant, and the RAM
// data passes through to o_rd_data in that cycle.
//
// Handshake: requester k holds i_req[k] and its attributes stable until it
// sees o_gnt[k]=1. The RAM access happens in the grant cycle. In the following
// cycle the requester may drop the request or present a new one.
//
// Ports:
//   i_clk, i_async_rst           clock and asynchronous active-high reset
//   i_req, i_req_is_wr           per-requester request and write flag
//   i_word_addr, i_byte_en,
//   i_wr_data                    per-requester slices; slice k belongs to requester k
//   i_lock                       per-requester lock (RAM_PORT_ARB_LOCK_EN only)
//   o_gnt                        one-hot grant
//   o_wr_ack, o_rd_ack           completion pulses
//   o_rd_data                    shared read data, qualified by o_rd_ack
//   o_ram_*                      RAM command from the winner, all 0 when idle
//   i_ram_rd_data                RAM data, valid RD_LAT cycles after the address
//
// Optional feature: define RAM_PORT_ARB_LOCK_EN to add i_lock. A locked
// holder then keeps winning for up to LOCK_MAX_BEATS consecutive grants.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_REQ               = 2,
  parameter int WORD_BIT_WIDTH      = 32,
  parameter int WORD_ADDR_BIT_WIDTH = 6,
  parameter int RD_LAT              = 1,
  parameter int LOCK_MAX_BEATS      = 8,
  localparam int BPW                = WORD_BIT_WIDTH / 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_async_rst,
  input  logic [N_REQ-1:0]                     i_req,
  input  logic [N_REQ-1:0]                     i_req_is_wr,
  input  logic [N_REQ*WORD_ADDR_BIT_WIDTH-1:0] i_word_addr,
  input  logic [N_REQ*BPW-1:0]                 i_byte_en,
  input  logic [N_REQ*WORD_BIT_WIDTH-1:0]      i_wr_data,
`ifdef RAM_PORT_ARB_LOCK_EN
  input  logic [N_REQ-1:0]                     i_lock,
`endif
  output logic [N_REQ-1:0]                     o_gnt,
  output logic [N_REQ-1:0]                     o_wr_ack,
  output logic [N_REQ-1:0]                     o_rd_ack,
  output logic [WORD_BIT_WIDTH-1:0]            o_rd_data,
  output logic                                 o_ram_we,
  output logic [WORD_ADDR_BIT_WIDTH-1:0]       o_ram_word_addr,
  output logic [BPW-1:0]                       o_ram_byte_en,
  output logic [WORD_BIT_WIDTH-1:0]            o_ram_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]            i_ram_rd_data
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int AW    = WORD_ADDR_BIT_WIDTH;
  localparam int W     = WORD_BIT_WIDTH;

  if (RD_LAT < 1 || RD_LAT > 2) begin : g_bad_rd_lat
    $error("ram_port_arbiter: RD_LAT must be 1 or 2");
  end
  if (N_REQ < 2 || N_REQ >= MAX_REQ) begin : g_bad_n_req
    $error("ram_port_arbiter: N_REQ out of range");
  end
  if (W < 8 || (W & (W - 1)) != 0) begin : g_bad_width
    $error("ram_port_arbiter: WORD_BIT_WIDTH must be a power of 2, at least 8");
  end
  if (LOCK_MAX_BEATS < 1 || LOCK_MAX_BEATS > 255) begin : g_bad_lock
    $error("ram_port_arbiter: LOCK_MAX_BEATS must be in 1..255");
  end

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_REQ-1:0]   wr_ack_q, wr_ack_d;
  logic [MAX_REQ-1:0] rr_gnt;
  logic [N_REQ-1:0]   gnt;
  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic               unused_rr_hi;
  rd_entry_t          rd_in, rd_tail;

`ifdef RAM_PORT_ARB_LOCK_EN
  logic [PTR_W-1:0] holder_q, holder_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             lock_win;

  // A count of 0 means no locked run is in progress, so the next grant is
  // made by round-robin. Once the count reaches LOCK_MAX_BEATS, one
  // round-robin arbitration happens before the holder can lock again.
  assign lock_win = (beat_cnt_q != 8'd0) && (beat_cnt_q < 8'(LOCK_MAX_BEATS))
                    && i_req[holder_q] && i_lock[holder_q];
`endif

  always_comb begin
    rr_gnt = rr_pick(MAX_REQ'(i_req), IDX_W'(ptr_q), N_REQ);
    gnt    = rr_gnt[N_REQ-1:0];
`ifdef RAM_PORT_ARB_LOCK_EN
    if (lock_win) begin
      gnt           = '0;
      gnt[holder_q] = 1'b1;
    end
`endif
    // The grant is combinational, so it is masked while reset is asserted.
    if (i_async_rst) begin
      gnt = '0;
    end
  end

  assign unused_rr_hi = |rr_gnt[MAX_REQ-1:N_REQ];
  assign gnt_any      = |gnt;
  assign o_gnt        = gnt;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = PTR_W'(i);
      end
    end
  end

  // RAM command mux. When there is no grant, every output is 0.
  always_comb begin
    o_ram_we        = 1'b0;
    o_ram_word_addr = '0;
    o_ram_byte_en   = '0;
    o_ram_wr_data   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        o_ram_we        = i_req_is_wr[i];
        o_ram_word_addr = i_word_addr[i*AW +: AW];
        o_ram_byte_en   = i_byte_en[i*BPW +: BPW];
        o_ram_wr_data   = i_wr_data[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
    wr_ack_d = gnt & i_req_is_wr;
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      ptr_q    <= '0;
      wr_ack_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign o_wr_ack = wr_ack_q;

`ifdef RAM_PORT_ARB_LOCK_EN
  // A grant to a locked requester either extends the current run (lock_win)
  // or starts a new run at 1. A grant to an unlocked requester, or a cycle
  // with no grant, ends the run.
  always_comb begin
    holder_d   = holder_q;
    beat_cnt_d = 8'd0;
    if (gnt_any) begin
      holder_d = gnt_idx;
      if (!i_lock[gnt_idx]) begin
        beat_cnt_d = 8'd0;
      end else if (lock_win) begin
        beat_cnt_d = beat_cnt_q + 8'd1;
      end else begin
        beat_cnt_d = 8'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      holder_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      holder_q   <= holder_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
`endif

  assign rd_in.valid = gnt_any & ~o_ram_we;
  assign rd_in.idx   = IDX_W'(gnt_idx);

  rd_ack_pipe #(.RD_LAT(RD_LAT)) u_rd_ack_pipe (
    .i_clk       (i_clk),
    .i_async_rst (i_async_rst),
    .i_entry     (rd_in),
    .o_entry     (rd_tail)
  );

  always_comb begin
    o_rd_ack = '0;
    for (int i = 0; i < N_REQ; i++) begin
      o_rd_ack[i] = rd_tail.valid && (rd_tail.idx == IDX_W'(i));
    end
    o_rd_data = rd_tail.valid ? i_ram_rd_data : '0;
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int N        = 3;
  localparam int W        = 32;
  localparam int AW       = 6;
  localparam int BPW      = W / 8;
  localparam int LOCK_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req, req_wr;
  logic [N*AW-1:0]  addr;
  logic [N*BPW-1:0] ben;
  logic [N*W-1:0]   wdata;
`ifdef RAM_PORT_ARB_LOCK_EN
  logic [N-1:0]     lock;
`endif

  logic [N-1:0]   gnt_a, wr_ack_a, rd_ack_a, gnt_b, wr_ack_b, rd_ack_b;
  logic [W-1:0]   rd_data_a, rd_data_b, ram_wdata_a, ram_wdata_b;
  logic           ram_we_a, ram_we_b;
  logic [AW-1:0]  ram_addr_a, ram_addr_b;
  logic [BPW-1:0] ram_ben_a, ram_ben_b;
  logic [W-1:0]   ram_q1, ram_q2;

  // Behavioural RAM driven by dut_a. Both DUTs see identical commands.
  // dut_a reads the 1-cycle output and dut_b reads the 2-cycle output.
  logic [W-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we_a) begin
      for (int b = 0; b < BPW; b++) begin
        if (ram_ben_a[b]) mem[ram_addr_a][b*8 +: 8] <= ram_wdata_a[b*8 +: 8];
      end
    end
    ram_q1 <= mem[ram_addr_a];
    ram_q2 <= ram_q1;
  end

  ram_port_arbiter #(.N_REQ(N), .WORD_BIT_WIDTH(W), .WORD_ADDR_BIT_WIDTH(AW),
                     .RD_LAT(1), .LOCK_MAX_BEATS(LOCK_MAX)) dut_a (
    .i_clk(clk), .i_async_rst(rst), .i_req(req), .i_req_is_wr(req_wr),
    .i_word_addr(addr), .i_byte_en(ben), .i_wr_data(wdata),
`ifdef RAM_PORT_ARB_LOCK_EN
    .i_lock(lock),
`endif
    .o_gnt(gnt_a), .o_wr_ack(wr_ack_a), .o_rd_ack(rd_ack_a), .o_rd_data(rd_data_a),
    .o_ram_we(ram_we_a), .o_ram_word_addr(ram_addr_a), .o_ram_byte_en(ram_ben_a),
    .o_ram_wr_data(ram_wdata_a), .i_ram_rd_data(ram_q1)
  );

  ram_port_arbiter #(.N_REQ(N), .WORD_BIT_WIDTH(W), .WORD_ADDR_BIT_WIDTH(AW),
                     .RD_LAT(2), .LOCK_MAX_BEATS(LOCK_MAX)) dut_b (
    .i_clk(clk), .i_async_rst(rst), .i_req(req), .i_req_is_wr(req_wr),
    .i_word_addr(addr), .i_byte_en(ben), .i_wr_data(wdata),
`ifdef RAM_PORT_ARB_LOCK_EN
    .i_lock(lock),
`endif
    .o_gnt(gnt_b), .o_wr_ack(wr_ack_b), .o_rd_ack(rd_ack_b), .o_rd_data(rd_data_b),
    .o_ram_we(ram_we_b), .o_ram_word_addr(ram_addr_b), .o_ram_byte_en(ram_ben_b),
    .o_ram_wr_data(ram_wdata_b), .i_ram_rd_data(ram_q2)
  );

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_ptr, m_holder, m_run;
  logic [W-1:0] m_mem [64];
  // Expected acks and data, keyed by the cycle in which they must appear.
  logic [N-1:0] sb_wr [int];
  logic [N-1:0] sb_rd1 [int];
  logic [N-1:0] sb_rd2 [int];
  logic [W-1:0] sb_d1 [int];
  logic [W-1:0] sb_d2 [int];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle();
    chk("rst_gnt", W'({gnt_b, gnt_a}), '0);
    chk("rst_ram_cmd", W'({ram_we_a, ram_we_b, ram_addr_a, ram_addr_b, ram_ben_a, ram_ben_b}), '0);
    chk("rst_wdata_a", ram_wdata_a, '0);
    chk("rst_wdata_b", ram_wdata_b, '0);
    chk("rst_acks", W'({wr_ack_a, wr_ack_b, rd_ack_a, rd_ack_b}), '0);
    chk("rst_rd_data_a", rd_data_a, '0);
    chk("rst_rd_data_b", rd_data_b, '0);
  endtask

  // Entered and left at a negedge. The caller drives the inputs first.
  task automatic step(input bit use_tab, input logic [N-1:0] tab_gnt, output int g);
    logic [N-1:0]   e_gnt, e_wr, e_rd1, e_rd2;
    logic [W-1:0]   e_d1, e_d2, e_wdata;
    logic           e_we;
    logic [AW-1:0]  e_addr;
    logic [BPW-1:0] e_ben;
    bit             locked;
    #1;
    g = -1;
    locked = 1'b0;
`ifdef RAM_PORT_ARB_LOCK_EN
    if (m_run > 0 && m_run < LOCK_MAX && req[m_holder] && lock[m_holder]) begin
      g = m_holder;
      locked = 1'b1;
    end
`endif
    if (g < 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[(m_ptr + i) % N]) begin
          g = (m_ptr + i) % N;
          break;
        end
      end
    end
    e_gnt = (g >= 0) ? (N'(1) << g) : '0;
    e_we = 1'b0; e_addr = '0; e_ben = '0; e_wdata = '0;
    if (g >= 0) begin
      e_we    = req_wr[g];
      e_addr  = addr[g*AW +: AW];
      e_ben   = ben[g*BPW +: BPW];
      e_wdata = wdata[g*W +: W];
    end
    e_wr  = sb_wr.exists(cyc)  ? sb_wr[cyc]  : '0;
    e_rd1 = sb_rd1.exists(cyc) ? sb_rd1[cyc] : '0;
    e_rd2 = sb_rd2.exists(cyc) ? sb_rd2[cyc] : '0;
    e_d1  = sb_d1.exists(cyc)  ? sb_d1[cyc]  : '0;
    e_d2  = sb_d2.exists(cyc)  ? sb_d2[cyc]  : '0;

    if (use_tab) chk("gnt_table", W'(gnt_a), W'(tab_gnt));
    chk("gnt_a", W'(gnt_a), W'(e_gnt));
    chk("gnt_b", W'(gnt_b), W'(e_gnt));
    chk("ram_cmd_a", W'({ram_we_a, ram_addr_a, ram_ben_a}), W'({e_we, e_addr, e_ben}));
    chk("ram_cmd_b", W'({ram_we_b, ram_addr_b, ram_ben_b}), W'({e_we, e_addr, e_ben}));
    chk("ram_wdata_a", ram_wdata_a, e_wdata);
    chk("ram_wdata_b", ram_wdata_b, e_wdata);
    chk("wr_ack_a", W'(wr_ack_a), W'(e_wr));
    chk("wr_ack_b", W'(wr_ack_b), W'(e_wr));
    chk("rd_ack_a", W'(rd_ack_a), W'(e_rd1));
    chk("rd_ack_b", W'(rd_ack_b), W'(e_rd2));
    chk("rd_data_a", rd_data_a, e_d1);
    chk("rd_data_b", rd_data_b, e_d2);

    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (e_we) begin
        for (int b = 0; b < BPW; b++) begin
          if (e_ben[b]) m_mem[e_addr][b*8 +: 8] = e_wdata[b*8 +: 8];
        end
        sb_wr[cyc+1] = e_gnt;
      end else begin
        sb_rd1[cyc+1] = e_gnt;
        sb_d1[cyc+1]  = m_mem[e_addr];
        sb_rd2[cyc+2] = e_gnt;
        sb_d2[cyc+2]  = m_mem[e_addr];
      end
    end
`ifdef RAM_PORT_ARB_LOCK_EN
    if (g >= 0) begin
      if (!lock[g]) m_run = 0;
      else if (locked) m_run = m_run + 1;
      else m_run = 1;
      m_holder = g;
    end else begin
      m_run = 0;
    end
`else
    if (locked) m_run = m_run + 1;
`endif
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '1; req_wr = '0;
    #1;
    chk_idle();
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_idle();
    m_ptr = 0; m_holder = 0; m_run = 0;
    sb_wr.delete(); sb_rd1.delete(); sb_rd2.delete(); sb_d1.delete(); sb_d2.delete();
    req = '0;
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int k, input logic wr, input logic [AW-1:0] a,
                       input logic [BPW-1:0] be, input logic [W-1:0] d);
    req[k] = 1'b1;
    req_wr[k] = wr;
    addr[k*AW +: AW] = a;
    ben[k*BPW +: BPW] = be;
    wdata[k*W +: W] = d;
  endtask

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [W-1:0]  d0;
    logic [N-1:0]  gnt;
  } vec_t;

  function automatic vec_t mk(logic [N-1:0] r, logic [N-1:0] w, logic [AW-1:0] a0,
                              logic [AW-1:0] a1, logic [W-1:0] d0, logic [N-1:0] gn);
    vec_t v;
    v.req = r; v.wr = w; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.gnt = gn;
    return v;
  endfunction

  vec_t vecs[$];
  int   g;
  int   last_g;

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]   = $urandom;
      m_mem[i] = mem[i];
    end
    req = '0; req_wr = '0; addr = '0; ben = '0; wdata = '0;
`ifdef RAM_PORT_ARB_LOCK_EN
    lock = '0;
`endif
    m_ptr = 0; m_holder = 0; m_run = 0;

    // Contention, idle cycles, and three-way rotation with non-power-of-2 wrap.
    vecs.push_back(mk(3'b011, 3'b000, 6'd3, 6'd5, 32'h0, 3'b001));
    vecs.push_back(mk(3'b011, 3'b000, 6'd3, 6'd5, 32'h0, 3'b010));
    vecs.push_back(mk(3'b011, 3'b000, 6'd3, 6'd5, 32'h0, 3'b001));
    vecs.push_back(mk(3'b011, 3'b000, 6'd3, 6'd5, 32'h0, 3'b010));
    vecs.push_back(mk(3'b000, 3'b000, 6'd0, 6'd0, 32'h0, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 6'd0, 6'd0, 32'h0, 3'b000));
    vecs.push_back(mk(3'b111, 3'b001, 6'd1, 6'd2, 32'hA5A5_0001, 3'b100));
    vecs.push_back(mk(3'b111, 3'b001, 6'd1, 6'd2, 32'hA5A5_0002, 3'b001));
    vecs.push_back(mk(3'b111, 3'b000, 6'd1, 6'd2, 32'h0, 3'b010));
    vecs.push_back(mk(3'b101, 3'b000, 6'd1, 6'd2, 32'h0, 3'b100));
    vecs.push_back(mk(3'b110, 3'b000, 6'd1, 6'd2, 32'h0, 3'b010));
    vecs.push_back(mk(3'b011, 3'b010, 6'd1, 6'd2, 32'h1234_5678, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 6'd0, 6'd0, 32'h0, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 6'd0, 6'd0, 32'h0, 3'b000));

    @(negedge clk);
    do_reset();

    foreach (vecs[i]) begin
      req    = vecs[i].req;
      req_wr = vecs[i].wr;
      addr   = {vecs[i].a0 ^ vecs[i].a1, vecs[i].a1, vecs[i].a0};
      ben    = '1;
      wdata  = {vecs[i].d0 + 32'd1, ~vecs[i].d0, vecs[i].d0};
      step(1'b1, vecs[i].gnt, g);
    end

    // Write then read of the same address in back-to-back cycles.
    do_reset();
    drive(0, 1'b1, 6'd7, 4'hF, 32'hDEADBEEF);
    step(1'b1, 3'b001, g);
    chk("wr_then_rd_wr_ack", W'(wr_ack_a), W'(3'b001));
    req = '0;
    drive(1, 1'b0, 6'd7, 4'h0, 32'h0);
    step(1'b1, 3'b010, g);
    chk("wr_then_rd_data_lat1", rd_data_a, 32'hDEADBEEF);
    req = '0;
    step(1'b1, 3'b000, g);
    chk("wr_then_rd_ack_lat2", W'(rd_ack_b), W'(3'b010));
    chk("wr_then_rd_data_lat2", rd_data_b, 32'hDEADBEEF);
    step(1'b1, 3'b000, g);

    // Partial write onto an existing word.
    drive(0, 1'b1, 6'd9, 4'hF, 32'h11223344);
    step(1'b0, '0, g);
    drive(0, 1'b1, 6'd9, 4'b0010, 32'h0000AB00);
    step(1'b0, '0, g);
    req = '0;
    drive(1, 1'b0, 6'd9, 4'h0, 32'h0);
    step(1'b1, 3'b010, g);
    chk("partial_rd_lat1", rd_data_a, 32'h1122AB44);
    req = '0;
    step(1'b1, 3'b000, g);
    chk("partial_rd_lat2", rd_data_b, 32'h1122AB44);
    step(1'b1, 3'b000, g);

    // Reset one cycle after a read grant: that read is never acknowledged.
    drive(0, 1'b0, 6'd4, 4'h0, 32'h0);
    step(1'b1, 3'b001, g);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 3'b000, g);

    // Randomized traffic. An ungranted requester holds its request stable.
    last_g = -1;
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] || last_g == k) begin
          req[k]            = ($urandom_range(0, 3) != 0);
          req_wr[k]         = 1'($urandom_range(0, 1));
          addr[k*AW +: AW]  = AW'($urandom_range(0, 7));
          ben[k*BPW +: BPW] = BPW'($urandom_range(0, 15));
          wdata[k*W +: W]   = $urandom;
        end
      end
      step(1'b0, '0, last_g);
    end
    req = '0;
    step(1'b1, 3'b000, g);
    step(1'b1, 3'b000, g);

`ifdef RAM_PORT_ARB_LOCK_EN
    // Lock with LOCK_MAX_BEATS=3: requester 0 locked, requester 1 contending.
    do_reset();
    drive(0, 1'b0, 6'd2, 4'h0, 32'h0);
    drive(1, 1'b0, 6'd6, 4'h0, 32'h0);
    lock = 3'b001;
    step(1'b1, 3'b001, g);
    step(1'b1, 3'b001, g);
    step(1'b1, 3'b001, g);
    step(1'b1, 3'b010, g);
    step(1'b1, 3'b001, g);
    step(1'b1, 3'b001, g);
    req = '0;
    lock = '0;
    step(1'b1, 3'b000, g);
    step(1'b1, 3'b000, g);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
